work_loader: RTL and testbench
==============================

Name: work_loader

Overview:
- Upstream stage of miner_top. Receives mining work as a framed byte stream from the host link (UART/SPI byte receiver) and assembles the 608-bit header and 256-bit target.
- Validates each frame with an XOR checksum before use.
- Commits a validated frame atomically to the registered header/target outputs that drive miner_top, so the miner never sees a partially loaded job.

Parameters:
HEADER_BYTES, 76, header payload bytes; header width = 8*HEADER_BYTES (608)
TARGET_BYTES, 32, target payload bytes; target width = 8*TARGET_BYTES (256)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 50000, maximum idle clk cycles between bytes inside a frame (1 ms at 50 MHz)

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous active-high reset
in_data  input  8  incoming byte
in_valid  input  1  in_data valid; byte accepted when in_valid && in_ready
in_ready  output  1  loader can accept a byte
header  output  8*HEADER_BYTES  committed block header, to miner_top.header
target  output  8*TARGET_BYTES  committed target, to miner_top.target
work_valid  output  1  one-cycle pulse on the cycle header/target update
work_id  output  8  count of committed jobs, mod 256
err_checksum  output  1  one-cycle pulse: frame rejected on checksum mismatch
err_timeout  output  1  one-cycle pulse: partial frame discarded on inter-byte timeout

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: header=0, target=0, work_valid=0, work_id=0, err_*=0, in_ready=0.
  - Internal state: FSM=IDLE, byte counter=0, checksum accumulator=0, timeout counter=0.
  - Reset mid-frame discards the partial frame. Committed outputs also clear.
- in_ready is registered: 1 from the first cycle after reset in IDLE, PAYLOAD and CHECK; 0 in COMMIT and in reset.
- Frame format: SYNC_BYTE, then HEADER_BYTES header bytes (MSB first), then TARGET_BYTES target bytes (MSB first), then 1 checksum byte. The checksum byte equals the XOR of all payload bytes, seed 8'h00.
- FSM states:
  - IDLE:
    - Accepted byte == SYNC_BYTE -> PAYLOAD; clear byte counter and accumulator.
    - Any other byte is dropped silently; no error pulse.
  - PAYLOAD:
    - Each accepted byte is written into a shadow register at position byte_cnt. Byte 0 goes to header[607:600]; byte HEADER_BYTES goes to target[255:248].
    - The accumulator XORs in the byte; byte_cnt increments.
    - After byte HEADER_BYTES+TARGET_BYTES-1 (byte_cnt wraps to 107 -> done) -> CHECK.
    - A SYNC_BYTE value inside the payload is data, not a restart.
  - CHECK:
    - Accepted byte == accumulator -> COMMIT.
    - Mismatch -> IDLE with err_checksum=1 for one cycle. Outputs are untouched.
  - COMMIT: one cycle. header/target <= shadow; work_valid=1; work_id += 1 (255 wraps to 0); -> IDLE.
- Latency: header/target/work_valid change on the 1st rising edge after the clock edge that accepted the checksum byte.
- Timeout:
  - In PAYLOAD and CHECK, the timeout counter increments on each cycle with no accepted byte and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: -> IDLE, err_timeout=1 for one cycle, shadow discarded.
  - If a byte is accepted on the cycle the counter would hit the limit, the byte wins and no timeout occurs.
  - The counter is held at 0 in IDLE and COMMIT.
- Shadow register is separate from the outputs. header/target hold the last committed job during any in-progress, failed or timed-out frame.
- Widths: byte_cnt $clog2(HEADER_BYTES+TARGET_BYTES) bits; timeout counter $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package miner_pkg:
  - HEADER_W=608, TARGET_W=256, NONCE_W=32.
  - SYNC_BYTE constant.
  - State enum {IDLE, PAYLOAD, CHECK, COMMIT}.
- One sub-module: frame_timeout_counter.
  - Inputs: clk, rst, enable, kick.
  - Output: expired.
  - Parameter: LIMIT.
- All other logic stays inline.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> header=0, target=0, work_id=0, in_ready=0 during reset, then in_ready=1 from the next cycle.
- Good frame, back-to-back bytes:
  - Stimulus: A5, 76 bytes of AA, 16 bytes of FF,00 pattern filling target = 256'h...FFFF0000FFFF0000FFFF0000FFFF0000 (upper 16 bytes 00), checksum = XOR of all payload.
  - Response: work_valid pulses once, 1 cycle after the checksum byte; header = {76{8'hAA}}; target = 256'h0000...FFFF0000FFFF0000FFFF0000FFFF0000; work_id = 1.
- Bad checksum: same frame with checksum ^ 8'h01 -> err_checksum pulses one cycle; header/target/work_id unchanged from the previous job; no work_valid.
- Garbage before sync: bytes 00, 13, 5A, then a valid frame -> garbage ignored with no error; frame commits normally.
- Timeout: A5 plus 40 payload bytes, then in_valid=0 for TIMEOUT_CYCLES (override to 100) -> err_timeout on cycle 100 of the gap. A following full valid frame commits correctly; a byte arriving at gap cycle 99 does not time out.
- Back-pressure and wrap:
  - in_valid held high across COMMIT -> byte not accepted while in_ready=0; no byte loss.
  - 256 consecutive good frames -> work_id wraps to 0.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and widths for the mining datapath.
// Used by the work loader and the miner core.
package miner_pkg;

  localparam int HEADER_W = 608;
  localparam int TARGET_W = 256;
  localparam int NONCE_W  = 32;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    COMMIT
  } state_e;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte idle watchdog for a frame in flight.
// expired fires on the idle cycle that would reach LIMIT.
module frame_timeout_counter #(
  parameter int LIMIT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // a byte on the limit cycle kicks first, so it always wins
  assign expired = enable && !kick
                && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || !enable || kick || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/work_loader.sv
// Framed byte-stream receiver that assembles header/target
// and commits checksum-verified jobs atomically to the miner.
module work_loader #(
  parameter int HEADER_BYTES = miner_pkg::HEADER_W / 8,
  parameter int TARGET_BYTES = miner_pkg::TARGET_W / 8,
  parameter logic [7:0] SYNC_BYTE = miner_pkg::SYNC_BYTE,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [8*HEADER_BYTES-1:0] header,
  output logic [8*TARGET_BYTES-1:0] target,
  output logic                      work_valid,
  output logic [7:0]                work_id,
  output logic                      err_checksum,
  output logic                      err_timeout
);

  import miner_pkg::*;

  localparam int FRAME_BYTES = HEADER_BYTES + TARGET_BYTES;
  localparam int HW = 8 * HEADER_BYTES;
  localparam int TW = 8 * TARGET_BYTES;
  localparam int SW = HW + TW;
  localparam int CNT_W = $clog2(FRAME_BYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BYTES - 1);

  state_e           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       acc;
  logic [SW-1:0]    shadow;
  logic             accept;
  logic             busy;
  logic             expired;

  assign accept = in_valid && in_ready;
  assign busy   = (state == PAYLOAD) || (state == CHECK);

  frame_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (busy),
    .kick    (accept),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      acc          <= '0;
      shadow       <= '0;
      header       <= '0;
      target       <= '0;
      work_valid   <= 1'b0;
      work_id      <= '0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      in_ready     <= 1'b0;
    end else begin
      work_valid   <= 1'b0;
      err_checksum <= 1'b0;
      err_timeout  <= 1'b0;
      in_ready     <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept && in_data == SYNC_BYTE) begin
            state    <= PAYLOAD;
            byte_cnt <= '0;
            acc      <= '0;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            // shifting MSB-first lands byte 0 at the header top
            shadow <= {shadow[SW-9:0], in_data};
            acc    <= acc ^ in_data;
            if (byte_cnt == LAST) begin
              byte_cnt <= '0;
              state    <= CHECK;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (expired) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end
        end
        CHECK: begin
          if (accept) begin
            if (in_data == acc) begin
              state    <= COMMIT;
              in_ready <= 1'b0;
            end else begin
              state        <= IDLE;
              err_checksum <= 1'b1;
            end
          end else if (expired) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end
        end
        COMMIT: begin
          header     <= shadow[SW-1 -: HW];
          target     <= shadow[TW-1:0];
          work_valid <= 1'b1;
          work_id    <= work_id + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_work_loader.sv
// Directed bench for work_loader with a shortened timeout.
// Frames, checksum errors, timeouts, back-pressure, id wrap.
module tb_work_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [607:0] header;
  logic [255:0] target;
  logic         work_valid;
  logic [7:0]   work_id;
  logic         err_checksum;
  logic         err_timeout;

  int checks = 0;
  int errors = 0;

  logic [607:0] h1;
  logic [255:0] t1;
  logic [607:0] h2;
  logic [255:0] t2;

  work_loader #(
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .header       (header),
    .target       (target),
    .work_valid   (work_valid),
    .work_id      (work_id),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs,
                         input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] obs,
                          input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_hdr(input string tag, input logic [607:0] obs,
                         input logic [607:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tgt(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // returns on the posedge that accepts the byte
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      assert (in_ready === 1'b1) else begin
        errors++;
        $error("FAIL send_stall: observed %b expected 1", in_ready);
      end
    end
    @(posedge clk);
  endtask

  task automatic send_body(input logic [607:0] hdr,
                           input logic [255:0] tgt,
                           input logic [7:0] cs,
                           input int gap_at, input int gap_len);
    logic [7:0] b;
    for (int i = 0; i < 108; i++) begin
      if (i == gap_at) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap_len - 1) @(posedge clk);
      end
      if (i < 76) b = hdr[607 - 8*i -: 8];
      else        b = tgt[255 - 8*(i-76) -: 8];
      send_byte(b);
    end
    send_byte(cs);
  endtask

  task automatic send_frame(input logic [607:0] hdr,
                            input logic [255:0] tgt,
                            input logic [7:0] cs,
                            input int gap_at, input int gap_len);
    send_byte(8'hA5);
    send_body(hdr, tgt, cs, gap_at, gap_len);
  endtask

  task automatic finish_commit(input logic [607:0] eh,
                               input logic [255:0] et,
                               input logic [7:0] eid);
    @(negedge clk);
    in_valid = 1'b0;
    chk_bit("commit_ready_low", in_ready, 1'b0);
    chk_bit("commit_wv_early", work_valid, 1'b0);
    @(negedge clk);
    chk_bit("commit_wv", work_valid, 1'b1);
    chk_hdr("commit_header", header, eh);
    chk_tgt("commit_target", target, et);
    chk_byte("commit_id", work_id, eid);
    @(negedge clk);
    chk_bit("commit_wv_drop", work_valid, 1'b0);
    chk_bit("commit_ready_back", in_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_hdr("rst_header", header, '0);
    chk_tgt("rst_target", target, '0);
    chk_byte("rst_id", work_id, 8'h00);
    chk_bit("rst_ready", in_ready, 1'b0);
    chk_bit("rst_wv", work_valid, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_bit("post_rst_ready", in_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    h1 = {76{8'hAA}};
    t1 = 256'h00000000_00000000_00000000_00000000_FFFF0000_FFFF0000_FFFF0000_FFFF0000;
    for (int i = 0; i < 76; i++) h2[607 - 8*i -: 8] = 8'(i);
    t2 = {8'hA5, {30{8'h5A}}, 8'h3C};

    do_reset();

    // good frame: XOR of 76 AA and 8 FF is zero
    send_frame(h1, t1, 8'h00, -1, 0);
    finish_commit(h1, t1, 8'd1);

    // bad checksum
    send_frame(h1, t1, 8'h01, -1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_bit("cs_err_pulse", err_checksum, 1'b1);
    chk_bit("cs_no_wv", work_valid, 1'b0);
    @(negedge clk);
    chk_bit("cs_err_drop", err_checksum, 1'b0);
    chk_bit("cs_no_wv2", work_valid, 1'b0);
    chk_hdr("cs_header_kept", header, h1);
    chk_byte("cs_id_kept", work_id, 8'd1);

    // garbage before sync; payload holds an A5 data byte, checksum 99
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h5A);
    @(negedge clk);
    chk_bit("garbage_no_cs_err", err_checksum, 1'b0);
    chk_bit("garbage_no_to_err", err_timeout, 1'b0);
    send_frame(h2, t2, 8'h99, -1, 0);
    finish_commit(h2, t2, 8'd2);

    // timeout after 40 payload bytes
    send_byte(8'hA5);
    for (int i = 0; i < 40; i++) send_byte(8'h11);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk_bit("to_gap99_quiet", err_timeout, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_bit("to_gap100_pulse", err_timeout, 1'b1);
    @(negedge clk);
    chk_bit("to_pulse_drop", err_timeout, 1'b0);
    chk_hdr("to_header_kept", header, h2);
    chk_byte("to_id_kept", work_id, 8'd2);
    send_frame(h1, t1, 8'h00, -1, 0);
    finish_commit(h1, t1, 8'd3);

    // byte on gap cycle 99 survives
    send_frame(h2, t2, 8'h99, 40, 99);
    finish_commit(h2, t2, 8'd4);

    // sync byte held through COMMIT must not be lost
    send_frame(h1, t1, 8'h00, -1, 0);
    @(negedge clk);
    in_data = 8'hA5;
    chk_bit("bp_ready_low", in_ready, 1'b0);
    @(negedge clk);
    chk_bit("bp_wv", work_valid, 1'b1);
    chk_bit("bp_ready_high", in_ready, 1'b1);
    chk_hdr("bp_header", header, h1);
    chk_byte("bp_id", work_id, 8'd5);
    @(posedge clk);
    send_body(h2, t2, 8'h99, -1, 0);
    finish_commit(h2, t2, 8'd6);

    // reset mid-frame clears everything
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(8'h77);
    do_reset();

    // id wrap
    for (int f = 0; f < 255; f++) send_frame(h1, t1, 8'h00, -1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk_byte("wrap_id_255", work_id, 8'd255);
    send_frame(h1, t1, 8'h00, -1, 0);
    finish_commit(h1, t1, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
